// File: rtl/rom_image_loader.sv
// rtl/rom_image_loader.sv - streams a byte image into a sync-read memory, then sweeps it back and compares sums.
module rom_image_loader #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [DATA_WIDTH-1:0] checksum
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_VERIFY, S_DRAIN, S_DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] lsum_q, lsum_d;
    logic [DATA_WIDTH-1:0] rsum_q, rsum_d;
    logic [1:0]            rv_q, rv_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lsum_d      = lsum_q;
        rsum_d      = rsum_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;
        // rv_q[1] marks mem_rdata holding the word for an address driven two edges ago
        rv_d        = {rv_q[0], 1'b0};
        if (rv_q[1]) begin
            rsum_d = rsum_q + mem_rdata;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                    lsum_d  = '0;
                    rsum_d  = '0;
                    rv_d    = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = cnt_q;
                    mem_wdata_d = in_data;
                    lsum_d      = lsum_q + in_data;
                    cnt_d       = cnt_q + ADDR_WIDTH'(1);
                    if (cnt_q == LAST) begin
                        state_d = S_VERIFY;
                        cnt_d   = '0;
                    end
                end
            end
            S_VERIFY: begin
                mem_addr_d = cnt_q;
                cnt_d      = cnt_q + ADDR_WIDTH'(1);
                rv_d[0]    = 1'b1;
                if (cnt_q == LAST) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (rv_q == 2'b00) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    error_d = (rsum_q != lsum_q);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            lsum_q      <= '0;
            rsum_q      <= '0;
            rv_q        <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lsum_q      <= lsum_d;
            rsum_q      <= rsum_d;
            rv_q        <= rv_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign in_ready  = (state_q == S_LOAD);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign checksum  = lsum_q;

endmodule

// File: tb/tb_rom_image_loader.sv
// tb/tb_rom_image_loader.sv - scoreboard bench: expected writes/results queued by the driver, checked by a monitor.
module tb_rom_image_loader;

    localparam int AW    = 7;
    localparam int DW    = 8;
    localparam int DEPTH = 128;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic          done;
    logic          error;
    logic [DW-1:0] checksum;

    rom_image_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .done(done), .error(error), .checksum(checksum)
    );

    always #5 clk = ~clk;

    // 1-cycle synchronous-read RAM, optionally corrupting address 5 on readback
    logic [DW-1:0] ram [DEPTH];
    logic          corrupt = 1'b0;
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr] + ((corrupt && mem_addr == 7'd5) ? 8'd1 : 8'd0);
    end

    typedef struct {
        logic [DW-1:0] cks;
        logic          err;
    } res_t;

    logic [15:0] wr_q [$];
    res_t        res_q [$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_acc = 0;
    logic        done_prev = 1'b0;
    logic [AW-1:0] exp_addr;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst_n && in_valid && in_ready) last_acc <= cyc;
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        logic [15:0] e;
        res_t r;
        if (rst_n && mem_we) begin
            if (wr_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with nothing expected", mem_addr, mem_wdata);
            end else begin
                e = wr_q.pop_front();
                chk("wr_addr", int'(mem_addr), int'(e[14:8]));
                chk("wr_data", int'(mem_wdata), int'(e[7:0]));
            end
        end
        if (done && !done_prev) begin
            if (res_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: done rose with no run pending");
            end else begin
                r = res_q.pop_front();
                chk("done_error", int'(error), int'(r.err));
                chk("done_checksum", int'(checksum), int'(r.cks));
                chk("done_busy", int'(busy), 0);
                chk("done_latency", cyc - 1 - last_acc, 131);
            end
        end
        done_prev = done;
    end

    task automatic check_zero(input string tag);
        chk({tag, "_in_ready"}, int'(in_ready), 0);
        chk({tag, "_mem_we"}, int'(mem_we), 0);
        chk({tag, "_mem_addr"}, int'(mem_addr), 0);
        chk({tag, "_mem_wdata"}, int'(mem_wdata), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_error"}, int'(error), 0);
        chk({tag, "_checksum"}, int'(checksum), 0);
    endtask

    task automatic send(input logic [DW-1:0] d, input logic st);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        start    = st;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready never rose");
        end
        @(posedge clk);
        wr_q.push_back({1'b0, exp_addr, d});
        exp_addr = exp_addr + 7'd1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_clears_done", int'(done), 0);
        chk("start_clears_error", int'(error), 0);
        chk("start_sets_busy", int'(busy), 1);
        exp_addr = '0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL done_timeout: done never rose");
        end
    endtask

    // mode 0: ramp 0..127, otherwise constant byte 'val'
    task automatic run(input int mode, input logic [DW-1:0] val, input bit stall, input bit mid_start,
                       input logic [DW-1:0] exp_cks, input logic exp_err);
        res_t r;
        pulse_start();
        r.cks = exp_cks;
        r.err = exp_err;
        res_q.push_back(r);
        for (int i = 0; i < DEPTH; i++) begin
            send((mode == 0) ? DW'(i) : val, mid_start && (i == 40));
            if (stall && (i % 10 == 9)) begin
                @(negedge clk);
                in_valid = 1'b0;
                start    = 1'b0;
                repeat (2) @(negedge clk);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
        if (mid_start) begin
            repeat (20) @(negedge clk);
            chk("verify_busy", int'(busy), 1);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done();
        chk("final_checksum", int'(checksum), int'(exp_cks));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        exp_addr = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run(0, 8'h00, 1'b0, 1'b0, 8'hC0, 1'b0);
        run(0, 8'h00, 1'b1, 1'b0, 8'hC0, 1'b0);
        corrupt = 1'b1;
        run(0, 8'h00, 1'b0, 1'b0, 8'hC0, 1'b1);
        corrupt = 1'b0;
        run(0, 8'h00, 1'b0, 1'b1, 8'hC0, 1'b0);

        pulse_start();
        for (int i = 0; i < 50; i++) send(DW'(i), 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_zero("midrst");
        repeat (5) @(negedge clk);
        chk("midrst_pending_writes", wr_q.size(), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("post_rst");

        run(1, 8'hFF, 1'b0, 1'b0, 8'h80, 1'b0);
        chk("done_before_restart", int'(done), 1);
        run(1, 8'hA5, 1'b0, 1'b0, 8'h80, 1'b0);
        chk("final_done_held", int'(done), 1);

        repeat (5) @(negedge clk);
        chk("leftover_writes", wr_q.size(), 0);
        chk("leftover_results", res_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
